// File: rtl/hex_display_if.sv
`timescale 1ns/1ps
// Display-controller bus: value load request in, segment outputs and ready back.
// Latency: none, wiring only.
// Backpressure: load is honoured only while ready is high; no queuing.
//
// Ports (signals):
//   load, value, lz_en - capture request, hex value (nibble i -> digit i), leading-zero enable
//   blink_en           - live blink enable
//   ready              - controller idle, can accept load
//   HEX                - 7 active-low segments per digit, digit i at [7i+6:7i], a..g = bit0..bit6
interface hex_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    lz_en;
    logic                    blink_en;
    logic                    ready;
    logic [7*NUM_DIGITS-1:0] HEX;

    modport master (
        output load, value, lz_en, blink_en,
        input  ready, HEX
    );

    modport slave (
        input  load, value, lz_en, blink_en,
        output ready, HEX
    );
endinterface

// File: rtl/hex_display_ctrl.sv
`timescale 1ns/1ps
// Multi-digit 7-segment hex display controller with leading-zero blanking and blink.
// Latency: load at edge E0 -> new segments visible and ready=1 after edge E(NUM_DIGITS+1).
// Backpressure: ready low while scanning/committing; loads seen then are dropped.
//
// Ports:
//   CLOCK_50 - system clock, rising edge
//   Reset    - asynchronous, active-high; blanks display and returns to idle
//   disp     - hex_display_if slave (load/value/lz_en/blink_en in, ready/HEX out)
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    hex_display_if.slave disp
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                       state;
    logic                         ready_q;
    logic [NUM_DIGITS-1:0][3:0]   val_q;
    logic                         lz_q;
    logic [IW-1:0]                idx;
    logic                         seen_nz;
    logic [NUM_DIGITS-1:0]        blank_mask;
    logic [NUM_DIGITS-1:0][6:0]   seg_q;
    logic [CW-1:0]                blink_cnt;
    logic                         blink_phase;
    logic [3:0]                   scan_nib;

    function automatic logic [6:0] hex_enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign scan_nib = val_q[idx];

    // Scan runs most-significant digit first so seen_nz tells whether any
    // higher digit was non-zero; digit 0 is never blanked so zero shows "0".
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            val_q      <= '0;
            lz_q       <= 1'b0;
            idx        <= '0;
            seen_nz    <= 1'b0;
            blank_mask <= '0;
            seg_q      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (disp.load) begin
                        val_q      <= disp.value;
                        lz_q       <= disp.lz_en;
                        idx        <= IW'(NUM_DIGITS - 1);
                        seen_nz    <= 1'b0;
                        blank_mask <= '0;
                        ready_q    <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    blank_mask[idx] <= lz_q && !seen_nz && (scan_nib == 4'h0) && (idx != '0);
                    if (scan_nib != 4'h0) begin
                        seen_nz <= 1'b1;
                    end
                    if (idx == '0) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        seg_q[i] <= blank_mask[i] ? SEG_BLANK : hex_enc(val_q[i]);
                    end
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Free-running blink timebase; phase 0 is the blanked half when enabled.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign disp.ready = ready_q;
    assign disp.HEX   = (disp.blink_en && !blink_phase) ? {NUM_DIGITS{SEG_BLANK}} : seg_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for hex_display_ctrl: a 4-digit and a 6-digit instance,
// directed loads push expected segments/latency, monitors check on ready rise.
module tb_hex_display_ctrl;
    logic clk;
    logic rst;

    hex_display_if #(.NUM_DIGITS(4)) ifa ();
    hex_display_if #(.NUM_DIGITS(6)) ifb ();

    hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4)) dut_a (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .disp     (ifa)
    );

    hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut_b (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .disp     (ifb)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [41:0] hex;
        int          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tests;
    int   fails;

    localparam logic [27:0] BLANK4 = {4{7'h7F}};
    localparam logic [41:0] BLANK6 = {6{7'h7F}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_a();
        bit   prev = 1'b1;
        int   cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                cnt  = 0;
            end else begin
                if (!ifa.ready) begin
                    cnt++;
                end else if (!prev) begin
                    if (qa.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL a_unexpected_commit: HEX %0h with nothing expected", ifa.HEX);
                    end else begin
                        e = qa.pop_front();
                        check("a_hex", 64'(ifa.HEX), 64'(e.hex));
                        check("a_latency", 64'(cnt), 64'(e.lat));
                    end
                    cnt = 0;
                end
                prev = ifa.ready;
            end
        end
    endtask

    task automatic mon_b();
        bit   prev = 1'b1;
        int   cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                cnt  = 0;
            end else begin
                if (!ifb.ready) begin
                    cnt++;
                end else if (!prev) begin
                    if (qb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL b_unexpected_commit: HEX %0h with nothing expected", ifb.HEX);
                    end else begin
                        e = qb.pop_front();
                        check("b_hex", 64'(ifb.HEX), 64'(e.hex));
                        check("b_latency", 64'(cnt), 64'(e.lat));
                    end
                    cnt = 0;
                end
                prev = ifb.ready;
            end
        end
    endtask

    task automatic load_a(input logic [15:0] v, input logic lz);
        ifa.value = v;
        ifa.lz_en = lz;
        ifa.load  = 1'b1;
        @(posedge clk);
        #1 ifa.load = 1'b0;
    endtask

    task automatic load_b(input logic [23:0] v, input logic lz);
        ifb.value = v;
        ifb.lz_en = lz;
        ifb.load  = 1'b1;
        @(posedge clk);
        #1 ifb.load = 1'b0;
    endtask

    initial begin
        logic [27:0] segs;
        bit          bl[16];
        int          bad;
        int          t;
        bit          found;

        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        // Load held through reset release must be taken on the first live edge.
        ifa.load     = 1'b1;
        ifa.value    = 16'h00A3;
        ifa.lz_en    = 1'b0;
        ifa.blink_en = 1'b0;
        ifb.load     = 1'b0;
        ifb.value    = '0;
        ifb.lz_en    = 1'b0;
        ifb.blink_en = 1'b0;

        fork
            mon_a();
            mon_b();
        join_none

        qa.push_back('{hex: 42'({7'h40, 7'h40, 7'h08, 7'h30}), lat: 5});

        #5;
        check("reset_ready_a", 64'(ifa.ready), 64'd1);
        check("reset_hex_a", 64'(ifa.HEX), 64'(BLANK4));
        check("reset_ready_b", 64'(ifb.ready), 64'd1);
        check("reset_hex_b", 64'(ifb.HEX), 64'(BLANK6));

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 ifa.load = 1'b0;
        repeat (8) @(negedge clk);

        qa.push_back('{hex: 42'({7'h7F, 7'h7F, 7'h08, 7'h30}), lat: 5});
        load_a(16'h00A3, 1'b1);
        repeat (8) @(negedge clk);

        qa.push_back('{hex: 42'({7'h7F, 7'h7F, 7'h7F, 7'h40}), lat: 5});
        load_a(16'h0000, 1'b1);
        repeat (8) @(negedge clk);

        // Second load two cycles into the scan must be dropped.
        qa.push_back('{hex: 42'({7'h79, 7'h24, 7'h30, 7'h19}), lat: 5});
        load_a(16'h1234, 1'b0);
        @(posedge clk);
        #1;
        ifa.value = 16'hFFFF;
        ifa.load  = 1'b1;
        @(posedge clk);
        #1 ifa.load = 1'b0;
        @(negedge clk);
        check("hex_hold_during_scan", 64'(ifa.HEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        repeat (8) @(negedge clk);

        segs = {7'h79, 7'h24, 7'h30, 7'h19};
        ifa.value = 16'hDEAD;
        ifa.lz_en = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_input_change", 64'(ifa.HEX), 64'(segs));

        // Blink: runs of 4 blank / 4 shown, non-blank samples show segs.
        ifa.blink_en = 1'b1;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bl[k] = (ifa.HEX == BLANK4);
            if (!bl[k] && ifa.HEX != segs) bad++;
        end
        t = -1;
        for (int k = 1; k <= 4; k++) begin
            if (t < 0 && bl[k] != bl[k-1]) t = k;
        end
        if (t < 0) begin
            bad++;
        end else begin
            for (int k = t; k < 16; k++) begin
                if (bl[k] != (bl[t] ^ bit'(((k - t) / 4) & 1))) bad++;
            end
        end
        check("blink_pattern", 64'(bad), 64'd0);

        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (ifa.HEX == BLANK4) found = 1'b1;
        end
        check("blink_blank_seen", 64'(found), 64'd1);
        ifa.blink_en = 1'b0;
        #1;
        check("blink_off_comb", 64'(ifa.HEX), 64'(segs));
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifa.HEX != segs) bad++;
        end
        check("blink_off_stable", 64'(bad), 64'd0);

        // Reset three cycles into an update aborts it and blanks at once.
        load_a(16'h5678, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", 64'(ifa.ready), 64'd1);
        check("abort_hex", 64'(ifa.HEX), 64'(BLANK4));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_hex_held", 64'(ifa.HEX), 64'(BLANK4));

        qa.push_back('{hex: 42'({7'h10, 7'h46, 7'h40, 7'h06}), lat: 5});
        load_a(16'h9C0E, 1'b1);
        repeat (8) @(negedge clk);

        qb.push_back('{hex: {7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40}, lat: 7});
        load_b(24'h000F00, 1'b1);
        repeat (10) @(negedge clk);

        qb.push_back('{hex: {6{7'h40}}, lat: 7});
        load_b(24'h000000, 1'b0);
        repeat (10) @(negedge clk);

        qb.push_back('{hex: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}, lat: 7});
        load_b(24'h000001, 1'b1);
        repeat (10) @(negedge clk);

        check("drain_a", 64'(qa.size()), 64'd0);
        check("drain_b", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of 7-segment digits driven (legal range 1..8).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, giving the blink half-period in clock cycles (legal minimum 2).
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: request to capture a new value.
REQ-006 The block SHALL have port value, input, 4*NUM_DIGITS bits: hex value; nibble i drives digit i, with digit 0 least significant.
REQ-007 The block SHALL have port lz_en, input, 1 bit: leading-zero suppression enable, sampled with load.
REQ-008 The block SHALL have port blink_en, input, 1 bit: blink enable, live (not latched).
REQ-009 The block SHALL have port ready, output, 1 bit: high when idle and able to accept load.
REQ-010 The block SHALL have port HEX, output, 7*NUM_DIGITS bits: segment outputs, with bits [7i+6:7i] for digit i, bit order a..g = bit0..bit6, active-low.

Function
REQ-011 Encoding SHALL be standard active-low hex: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E; a blank digit = 7'h7F.
REQ-012 FSM states SHALL be IDLE, SCAN and COMMIT; ready=1 only in IDLE.
REQ-013 IDLE with load=1 at a rising edge SHALL capture value and lz_en into internal registers, set the digit index to NUM_DIGITS-1, clear the seen_nonzero flag, and go to SCAN.
REQ-014 SCAN SHALL process one digit per cycle, index NUM_DIGITS-1 down to 0.
REQ-015 In SCAN, the blank-mask bit for digit i SHALL be set iff latched lz_en=1, seen_nonzero=0, nibble==0 and i!=0; otherwise seen_nonzero is set when nibble!=0.
REQ-016 After digit 0 is processed, SCAN SHALL go to COMMIT; COMMIT SHALL update the segment registers from captured nibbles and blank mask, then go to IDLE.
REQ-017 Latency: load sampled at edge E0 SHALL cause new segment registers to become visible, with ready=1, after edge E(NUM_DIGITS+1); this is 5 cycles at default.
REQ-018 load while not in IDLE SHALL be ignored; no queuing; the displayed value SHALL remain unchanged until COMMIT.
REQ-019 Digit 0 SHALL never be blanked by suppression, so value 0 with lz_en=1 shows a single "0".
REQ-020 A free-running blink counter SHALL count 0..BLINK_DIV-1 and wrap to 0, toggling blink_phase on each wrap, independent of blink_en and of FSM state.
REQ-021 HEX SHALL equal all-7'h7F when blink_en=1 and blink_phase=0; otherwise HEX SHALL equal the segment registers; blink_en changes SHALL take effect combinationally.
REQ-022 Changes of value or lz_en outside a load capture SHALL have no effect on HEX.

Reset
REQ-023 Reset=1 SHALL immediately, without a clock edge, force: FSM=IDLE, ready=1, segment registers all 7'h7F, blank mask 0, blink counter 0, blink_phase=1, captured value 0.
REQ-024 Reset asserted mid-SCAN or mid-COMMIT SHALL abort the update; HEX SHALL be blank after reset and SHALL NOT show a partial value.
REQ-025 load held high during reset release SHALL be captured at the first rising edge with Reset=0.

Verification
REQ-026 Default params: load value=16'h00A3, lz_en=0 -> ready low 5 cycles, then HEX3..HEX0 = 40,40,08,30.
REQ-027 load value=16'h00A3, lz_en=1 -> HEX3..HEX0 = 7F,7F,08,30; value=16'h0000, lz_en=1 -> 7F,7F,7F,40.
REQ-028 load value=16'h1234 then a second load of 16'hFFFF 2 cycles later -> second load ignored; HEX shows 79,24,30,19.
REQ-029 BLINK_DIV=4, blink_en=1 -> HEX alternates between blank and the segment registers every 4 cycles; blink_en=0 -> HEX stable.
REQ-030 Reset pulsed 3 cycles after load -> HEX all 7F, ready=1 asynchronously; next load completes normally.
REQ-031 NUM_DIGITS=6, value=24'h000F00, lz_en=1 -> digits 5..0 = 7F,7F,7F,0E,40,40; latency 7 cycles.
